// File: rtl/store_v.sv
// DRAM write-back stage for the STORE opcode: pulls packed tiles from the result
// buffer and writes their elements one byte per beat to consecutive DRAM addresses.
module store_v #(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_WIDTH = 256,
   parameter int ADDR_WIDTH = 24,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [ADDR_WIDTH-1:0] dram_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  tile_req,
   input  logic                  tile_valid,
   input  logic [TILE_WIDTH-1:0] tile_in,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   output logic                  valid_out
);

   localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
   localparam int IDX_W      = $clog2(TILE_ELEMS);
   localparam int CNT_W      = LEN_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [CNT_W-1:0]        elem_cnt_q;
   logic [IDX_W-1:0]        tile_idx_q;
   logic [TILE_WIDTH-1:0]   tile_q;
   logic                    busy_q, tile_req_q, mem_we_q, valid_out_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;

   logic [CNT_W-1:0]        elem_d;
   logic [IDX_W-1:0]        idx_d;
   logic                    last_elem, tile_end;

   assign elem_d    = elem_cnt_q + CNT_W'(1);
   assign idx_d     = tile_idx_q + IDX_W'(1);
   assign last_elem = (elem_d == CNT_W'(len_q));
   assign tile_end  = (tile_idx_q == IDX_W'(TILE_ELEMS - 1));

   // Outputs are precomputed one transition ahead so every port comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         elem_cnt_q  <= '0;
         tile_idx_q  <= '0;
         tile_q      <= '0;
         busy_q      <= 1'b0;
         tile_req_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         valid_out_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_in) begin
                  addr_q     <= dram_addr;
                  len_q      <= length;
                  elem_cnt_q <= '0;
                  tile_idx_q <= '0;
                  busy_q     <= 1'b1;
                  if (length == '0) begin
                     state_q     <= S_DONE;
                     valid_out_q <= 1'b1;
                  end else begin
                     state_q    <= S_FETCH;
                     tile_req_q <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (tile_valid) begin
                  tile_q      <= tile_in;
                  tile_idx_q  <= '0;
                  tile_req_q  <= 1'b0;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_q + ADDR_WIDTH'(elem_cnt_q);
                  mem_wdata_q <= tile_in[DATA_WIDTH-1:0];
                  state_q     <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (mem_ready) begin
                  elem_cnt_q <= elem_d;
                  tile_idx_q <= idx_d;
                  if (last_elem) begin
                     mem_we_q    <= 1'b0;
                     valid_out_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (tile_end) begin
                     mem_we_q   <= 1'b0;
                     tile_req_q <= 1'b1;
                     state_q    <= S_FETCH;
                  end else begin
                     mem_addr_q  <= addr_q + ADDR_WIDTH'(elem_d);
                     mem_wdata_q <= tile_q[DATA_WIDTH*int'(idx_d) +: DATA_WIDTH];
                  end
               end
            end
            S_DONE: begin
               valid_out_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign tile_req  = tile_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_store_v.sv
// Randomized bench for store_v: every accepted DRAM write is scored against the
// byte stream implied by the delivered tiles, base address and length.
module tb_store_v;

   localparam int AW = 24;
   localparam int LW = 10;
   localparam int TW = 256;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid_in = 1'b0;
   logic [AW-1:0] dram_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy, tile_req, mem_we, valid_out;
   logic          tile_valid = 1'b0;
   logic [TW-1:0] tile_in = '0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;

   store_v dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .dram_addr(dram_addr), .length(length),
      .busy(busy), .tile_req(tile_req), .tile_valid(tile_valid), .tile_in(tile_in),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [TW-1:0] rnd_tile();
      logic [TW-1:0] t;
      for (int i = 0; i < TW/32; i++) t[i*32 +: 32] = $urandom;
      return t;
   endfunction

   // operation context, written only by the stimulus process
   logic [AW-1:0] op_base = '0;
   int            op_len = 0;
   bit            op_active = 1'b0;
   int            op_wbase = 0;
   int            op_tbase = 0;
   int            rdy_mode = 0;
   int            tdelay = 0;

   // observation state, written only by the driver/monitor process
   logic [TW-1:0] tiles[$];
   int            wr_cnt = 0;
   int            treq_cyc = 0;
   int            vo_cnt = 0;
   int            wait_cnt = 0;
   int            cyc = 0;
   bit            stall_q = 1'b0;
   logic [AW-1:0] st_addr = '0;
   logic [DW-1:0] st_data = '0;

   always @(negedge clk) begin
      int            k, ti;
      logic [TW-1:0] t;
      logic [AW-1:0] ea;
      cyc++;
      case (rdy_mode)
         0:       mem_ready = 1'b1;
         1:       mem_ready = (cyc % 3 == 0);
         default: mem_ready = 1'($urandom % 2);
      endcase
      // tile source: answers a request after tdelay cycles, otherwise emits noise
      if (tile_req) begin
         if (wait_cnt == tdelay) begin
            tile_valid = 1'b1;
            tile_in    = rnd_tile();
            tiles.push_back(tile_in);
            wait_cnt   = 0;
         end else begin
            tile_valid = 1'b0;
            wait_cnt++;
         end
      end else begin
         tile_valid = 1'($urandom % 2);
         tile_in    = rnd_tile();
         wait_cnt   = 0;
      end
      if (!rst) begin
         if (tile_req) treq_cyc++;
         if (valid_out) vo_cnt++;
         if (stall_q) begin
            chk("stall_addr", 32'(mem_addr), 32'(st_addr));
            chk("stall_data", 32'(mem_wdata), 32'(st_data));
            chk("stall_we", 32'(mem_we), 32'd1);
         end
         if (mem_we && mem_ready) begin
            k = wr_cnt - op_wbase;
            if (!op_active) chk("stray_wr", 32'd1, 32'd0);
            else if (k >= op_len) chk("extra_wr", k, op_len - 1);
            else begin
               ea = op_base + AW'(k);
               chk("wr_addr", 32'(mem_addr), 32'(ea));
               ti = op_tbase + k / 32;
               if (ti < tiles.size()) begin
                  t = tiles[ti];
                  chk("wr_data", 32'(mem_wdata), 32'(t[(k % 32) * DW +: DW]));
               end else chk("tile_missing", ti, tiles.size() - 1);
            end
            wr_cnt++;
         end
         stall_q = mem_we && !mem_ready;
         st_addr = mem_addr;
         st_data = mem_wdata;
      end else stall_q = 1'b0;
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_treq"}, 32'(tile_req), 32'd0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_vo"}, 32'(valid_out), 32'd0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   task automatic start_op(input logic [AW-1:0] base, input int len, input int mode,
                           input int dly);
      @(negedge clk); #1;
      op_base   = base;
      op_len    = len;
      op_wbase  = wr_cnt;
      op_tbase  = tiles.size();
      rdy_mode  = mode;
      tdelay    = dly;
      op_active = 1'b1;
      valid_in  = 1'b1;
      dram_addr = base;
      length    = LW'(len);
      @(negedge clk); #1;
      valid_in  = 1'b0;
   endtask

   // One full store; ign pulses a stray start while the unit is busy.
   task automatic run_op(input logic [AW-1:0] base, input int len, input int mode,
                         input int dly, input bit ign);
      int lat, vo0, tr0, ntiles;
      vo0 = vo_cnt;
      tr0 = treq_cyc;
      ntiles = (len + 31) / 32;
      start_op(base, len, mode, dly);
      lat = 1;
      while (!valid_out && lat < 20000) begin
         @(negedge clk); #1;
         lat++;
         if (ign && lat == 3 && busy) begin
            valid_in  = 1'b1;
            dram_addr = AW'($urandom);
            length    = LW'($urandom);
         end else valid_in = 1'b0;
      end
      valid_in = 1'b0;
      chk("done_seen", 32'(valid_out), 32'd1);
      if (mode == 0) chk("latency", lat, ntiles * (dly + 1) + len + 1);
      chk("busy_at_done", 32'(busy), 32'd1);
      @(negedge clk); #1;
      chk("vo_pulse", 32'(valid_out), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("n_writes", wr_cnt - op_wbase, len);
      chk("n_tiles", tiles.size() - op_tbase, ntiles);
      chk("n_done", vo_cnt - vo0, 1);
      chk("treq_cycles", treq_cyc - tr0, ntiles * (dly + 1));
      op_active = 1'b0;
   endtask

   initial begin
      int vo0, wr0, tr0, n;
      repeat (3) @(negedge clk);
      #1 check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk); #1 check_idle_outputs("post_reset");

      run_op(24'h000100, 32, 0, 0, 1'b0);
      run_op(24'h002000, 40, 0, 0, 1'b0);
      run_op(AW'($urandom), 0, 0, 0, 1'b0);
      run_op(24'h000500, 70, 1, 4, 1'b0);
      run_op(24'hFFFFFE, 4, 0, 0, 1'b1);

      // abandon a 64-element store after ten writes
      start_op(24'h004000, 64, 0, 0);
      n = 0;
      while (wr_cnt - op_wbase < 10 && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      chk("mid_op_progress", 32'(wr_cnt - op_wbase >= 10), 32'd1);
      rst = 1'b1;
      #1 check_idle_outputs("mid_reset");
      op_active = 1'b0;
      vo0 = vo_cnt;
      wr0 = wr_cnt;
      tr0 = treq_cyc;
      @(negedge clk); #1 rst = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      chk("abandon_vo", vo_cnt - vo0, 0);
      chk("abandon_wr", wr_cnt - wr0, 0);
      chk("abandon_treq", treq_cyc - tr0, 0);

      run_op(24'h000300, 64, 0, 0, 1'b0);
      run_op(24'hFFFF00, 1023, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++)
         run_op(AW'($urandom), int'($urandom_range(0, 300)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'($urandom % 2));

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/store_v.md
Name: store_v

Overview:
- DRAM write-back stage directly downstream of the execution unit; implements the STORE opcode (0x03).
- On a start pulse it pulls packed tiles of result elements from a buffer source, one tile at a time, over a req/valid handshake.
- It writes each element as one byte to DRAM, at consecutive addresses from a base address, using a ready-throttled write port.
- It pulses done when the last element is accepted.

Parameters:
- DATA_WIDTH, 8, bits per element and per DRAM write beat.
- TILE_WIDTH, 256, bits per tile; TILE_ELEMS = TILE_WIDTH/DATA_WIDTH (32).
- ADDR_WIDTH, 24, DRAM byte-address width.
- LEN_WIDTH, 10, width of the element count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  start pulse; sampled only in IDLE.
- dram_addr  in  ADDR_WIDTH  base byte address; latched with valid_in.
- length  in  LEN_WIDTH  number of elements to store; latched with valid_in.
- busy  out  1  high in every state except IDLE.
- tile_req  out  1  request for the next tile.
- tile_valid  in  1  tile_in holds the requested tile.
- tile_in  in  TILE_WIDTH  packed tile; element j is tile_in[j*DATA_WIDTH +: DATA_WIDTH].
- mem_we  out  1  DRAM write request.
- mem_addr  out  ADDR_WIDTH  DRAM byte address.
- mem_wdata  out  DATA_WIDTH  DRAM write data.
- mem_ready  in  1  DRAM accepts the current write this cycle.
- valid_out  out  1  one-cycle done pulse.

Behaviour:
- Reset state: rst (async, active-high) forces IDLE. busy, tile_req, mem_we and valid_out are 0. mem_addr, mem_wdata and all counters are 0.
- States: IDLE, FETCH, WRITE, DONE. All outputs are registered or decoded from state only; no input-to-output combinational paths.
- IDLE:
  - On valid_in: latch dram_addr into addr_reg and length into len_reg; clear elem_cnt and tile_idx.
  - length==0 goes to DONE; otherwise goes to FETCH.
  - valid_in in any other state is ignored; it is not queued.
- FETCH:
  - tile_req=1, held until tile_valid.
  - On the cycle tile_valid=1: capture tile_in into tile_reg, set tile_idx=0, go to WRITE.
  - tile_valid outside FETCH is ignored.
- WRITE:
  - mem_we=1.
  - mem_addr = addr_reg + elem_cnt, modulo 2^ADDR_WIDTH, so addresses wrap at 0xFFFFFF to 0x000000.
  - mem_wdata = tile_reg element tile_idx.
  - Outputs hold stable while mem_ready=0.
  - When mem_ready=1, elem_cnt and tile_idx increment. Then:
    - if elem_cnt+1 == len_reg, go to DONE;
    - else if tile_idx == TILE_ELEMS-1, go to FETCH;
    - else stay in WRITE.
- Partial last tile: only the first len_reg mod TILE_ELEMS elements are written; the rest are discarded. The number of tiles fetched is ceil(len_reg/TILE_ELEMS).
- DONE: valid_out=1 for exactly one cycle, then go to IDLE. A valid_in on the cycle after DONE is accepted.
- Latency:
  - With mem_ready and tile_valid tied high, N elements and T=ceil(N/32) tiles: valid_out is high T+N+1 cycles after the valid_in sampling edge.
  - length==0: valid_out is high 1 cycle after that edge.
- Counter widths: elem_cnt is LEN_WIDTH+1 bits; it must not overflow at length=1023. tile_idx is log2(TILE_ELEMS) bits.
- Reset mid-operation: return to IDLE immediately. No further mem_we or tile_req. The latched transfer is abandoned and no valid_out is issued.

Test Plan:
- Single full tile: length=32, addr=0x000100, tile bytes 0..31, ready high → 32 writes to 0x100..0x11F with data 0..31; one tile_req cycle; valid_out 34 cycles after start.
- Partial second tile: length=40 → 2 tile fetches; 40 writes to consecutive addresses; bytes 8..31 of tile 2 never written; valid_out exactly once.
- Zero length: length=0 → no tile_req, no mem_we; valid_out on the next cycle; busy high for 1 cycle.
- Backpressure: mem_ready toggled 1-in-3, tile_valid delayed 5 cycles → mem_addr/mem_wdata stable while stalled; tile_req held 5 cycles; no duplicate or skipped addresses.
- Wrap and ignore: addr=0xFFFFFE, length=4 → writes to 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; a valid_in pulse during WRITE has no effect.
- Reset mid-op: rst asserted after 10 of 64 writes → all outputs 0 immediately; no valid_out; a new start after reset completes normally.
